// File: rtl/cnt_pkg.sv
// Shared helpers for the modulus counters.
// A modulus code of CNT_M_FULL (0) stands for 2^w; any other code is literal.
// mlim() returns the highest count value for a modulus code, computed one bit
// wider than the counter so that 2^w-1 and m-1 never truncate.
// Counter widths up to CNT_WMAX bits are supported.
package cnt_pkg;

  localparam int unsigned CNT_WMAX   = 32;
  localparam int unsigned CNT_M_FULL = 0;

  typedef logic [CNT_WMAX:0] cnt_wide_t;

  function automatic cnt_wide_t mlim(input logic [CNT_WMAX-1:0] m,
                                     input int unsigned         w);
    if (m == CNT_WMAX'(CNT_M_FULL))
      return (cnt_wide_t'(1) << w) - cnt_wide_t'(1);
    return cnt_wide_t'(m) - cnt_wide_t'(1);
  endfunction

endpackage

// File: rtl/modm_term_det.sv
// Terminal-value detector for the modulus counter.
//   i_q      : current count
//   i_m_cur  : current modulus code (0 = 2^W)
//   i_up_eff : effective direction (1 = up)
//   o_at_top : counting up and q is at the top value (modulus - 1)
//   o_at_bot : counting down and q is at zero
module modm_term_det
  import cnt_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] i_q,
  input  logic [W-1:0] i_m_cur,
  input  logic         i_up_eff,
  output logic         o_at_top,
  output logic         o_at_bot
);

  cnt_wide_t w_mlim;

  assign w_mlim   = mlim(CNT_WMAX'(i_m_cur), W);
  assign o_at_top = i_up_eff & (cnt_wide_t'(i_q) == w_mlim);
  assign o_at_bot = ~i_up_eff & (i_q == '0);

endmodule

// File: rtl/modm_updown_cnt.sv
// Programmable modulus-M up/down counter with runtime-writable modulus,
// synchronous range-checked load, cascade terminal count and wrap pulse.
//   clk, clr     : clock (rising edge), asynchronous active-high reset
//   en, up       : count enable and direction (1 = up); registered once
//                  before use when EN_REG != 0
//   ld, d        : synchronous load; out-of-range d loads 0 and sets ld_err
//   m_wr, m_in   : modulus write (m_in = 0 means 2^W)
//   q, m_cur     : count value and current modulus code
//   tc           : combinational terminal count for chaining into en
//   wrap         : tc delayed by one clock
//   ld_err       : sticky out-of-range load flag, cleared only by clr
module modm_updown_cnt
  import cnt_pkg::*;
#(
  parameter int unsigned W      = 4,
  parameter int unsigned M_DEF  = 11,
  parameter int unsigned EN_REG = 1
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic         up,
  input  logic         ld,
  input  logic [W-1:0] d,
  input  logic         m_wr,
  input  logic [W-1:0] m_in,
  output logic [W-1:0] q,
  output logic [W-1:0] m_cur,
  output logic         tc,
  output logic         wrap,
  output logic         ld_err
);

  logic         w_en_eff;
  logic         w_up_eff;

  logic [W-1:0] r_q;
  logic [W-1:0] r_m_cur;
  logic         r_wrap;
  logic         r_ld_err;

  logic         w_at_top;
  logic         w_at_bot;
  logic [W-1:0] w_m_new;
  cnt_wide_t    w_mlim_new;
  logic [W-1:0] w_step;
  logic [W-1:0] w_q_nxt;
  logic         w_ld_bad;
  logic         w_clip;

  generate
    if (EN_REG != 0) begin : g_en_reg
      logic r_en_q;
      logic r_up_q;

      always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
          r_en_q <= 1'b0;
          r_up_q <= 1'b1;
        end else begin
          r_en_q <= en;
          r_up_q <= up;
        end
      end

      assign w_en_eff = r_en_q;
      assign w_up_eff = r_up_q;
    end else begin : g_en_dir
      assign w_en_eff = en;
      assign w_up_eff = up;
    end
  endgenerate

  modm_term_det #(
    .W (W)
  ) u_term_det (
    .i_q      (r_q),
    .i_m_cur  (r_m_cur),
    .i_up_eff (w_up_eff),
    .o_at_top (w_at_top),
    .o_at_bot (w_at_bot)
  );

  assign w_m_new    = m_wr ? m_in : r_m_cur;
  assign w_mlim_new = mlim(CNT_WMAX'(w_m_new), W);
  assign w_ld_bad   = cnt_wide_t'(d) > w_mlim_new;

  // Step with the modulus in force before this edge. The down-wrap target
  // m_cur-1 taken modulo 2^W is exactly the top value, including code 0.
  always_comb begin
    w_step = r_q;
    if (w_en_eff) begin
      if (w_up_eff)
        w_step = w_at_top ? '0 : r_q + W'(1);
      else
        w_step = w_at_bot ? r_m_cur - W'(1) : r_q - W'(1);
    end
  end

  // A modulus write that shrinks the range below the stepped value clears q.
  assign w_clip = m_wr & (cnt_wide_t'(w_step) > w_mlim_new);

  always_comb begin
    w_q_nxt = w_step;
    if (ld)
      w_q_nxt = w_ld_bad ? '0 : d;
    else if (w_clip)
      w_q_nxt = '0;
  end

  assign tc = w_en_eff & ~ld & (w_at_top | w_at_bot);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_q      <= '0;
      r_m_cur  <= W'(M_DEF);
      r_wrap   <= 1'b0;
      r_ld_err <= 1'b0;
    end else begin
      r_q     <= w_q_nxt;
      r_m_cur <= w_m_new;
      r_wrap  <= tc;
      if (ld && w_ld_bad)
        r_ld_err <= 1'b1;
    end
  end

  assign q      = r_q;
  assign m_cur  = r_m_cur;
  assign wrap   = r_wrap;
  assign ld_err = r_ld_err;

endmodule

// File: tb/tb_modm_updown_cnt.sv
// Bench for modm_updown_cnt: an EN_REG=1 and an EN_REG=0 instance share the
// same stimulus and are compared every cycle against modular-arithmetic
// models; directed phases also pin exact literal values.
module tb_modm_updown_cnt;

  localparam int FULL = 16;

  logic       clk = 1'b0;
  logic       clr;
  logic       en;
  logic       up;
  logic       ld;
  logic [3:0] d;
  logic       m_wr;
  logic [3:0] m_in;

  logic [3:0] q_o     [2];
  logic [3:0] mcur_o  [2];
  logic       tc_o    [2];
  logic       wrap_o  [2];
  logic       err_o   [2];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int q;
    int m;
    int enq;
    int upq;
    int wrap;
    int err;
  } model_t;

  model_t mdl [2];

  always #5 clk = ~clk;

  modm_updown_cnt #(.W(4), .M_DEF(11), .EN_REG(1)) dut (
    .clk(clk), .clr(clr), .en(en), .up(up), .ld(ld), .d(d),
    .m_wr(m_wr), .m_in(m_in), .q(q_o[0]), .m_cur(mcur_o[0]),
    .tc(tc_o[0]), .wrap(wrap_o[0]), .ld_err(err_o[0])
  );

  modm_updown_cnt #(.W(4), .M_DEF(11), .EN_REG(0)) dut0 (
    .clk(clk), .clr(clr), .en(en), .up(up), .ld(ld), .d(d),
    .m_wr(m_wr), .m_in(m_in), .q(q_o[1]), .m_cur(mcur_o[1]),
    .tc(tc_o[1]), .wrap(wrap_o[1]), .ld_err(err_o[1])
  );

  task automatic chk(input string nm, input int inst, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s inst%0d got %0d expected %0d at %0t", nm, inst, act, exp, $time);
    end
  endtask

  function automatic model_t mdl_reset();
    model_t r;
    r.q = 0; r.m = 11; r.enq = 0; r.upq = 1; r.wrap = 0; r.err = 0;
    return r;
  endfunction

  function automatic int modulus(input int code);
    return (code == 0) ? FULL : code;
  endfunction

  function automatic int exp_tc(input model_t s, input int inst);
    int mo, ee, ue;
    mo = modulus(s.m);
    ee = (inst == 0) ? s.enq : int'(en);
    ue = (inst == 0) ? s.upq : int'(up);
    return int'(ee != 0 && !ld && ((ue != 0) ? (s.q == mo - 1) : (s.q == 0)));
  endfunction

  function automatic model_t mdl_next(input model_t s, input int inst);
    model_t r;
    int mo, mn, ee, ue, stp;
    r  = s;
    mo = modulus(s.m);
    mn = m_wr ? modulus(int'(m_in)) : mo;
    ee = (inst == 0) ? s.enq : int'(en);
    ue = (inst == 0) ? s.upq : int'(up);
    if (ld) begin
      if (int'(d) < mn) r.q = int'(d);
      else begin r.q = 0; r.err = 1; end
    end else begin
      stp = s.q;
      if (ee != 0) stp = (ue != 0) ? (s.q + 1) % mo : (s.q + mo - 1) % mo;
      if (m_wr && stp >= mn) stp = 0;
      r.q = stp;
    end
    r.m    = m_wr ? int'(m_in) : s.m;
    r.enq  = int'(en);
    r.upq  = int'(up);
    r.wrap = exp_tc(s, inst);
    return r;
  endfunction

  always @(posedge clk or posedge clr) begin
    for (int i = 0; i < 2; i++) begin
      if (clr) mdl[i] <= mdl_reset();
      else     mdl[i] <= mdl_next(mdl[i], i);
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk("q",      i, int'(q_o[i]),    mdl[i].q);
      chk("m_cur",  i, int'(mcur_o[i]), mdl[i].m);
      chk("tc",     i, int'(tc_o[i]),   exp_tc(mdl[i], i));
      chk("wrap",   i, int'(wrap_o[i]), mdl[i].wrap);
      chk("ld_err", i, int'(err_o[i]),  mdl[i].err);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int exp1 [13] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0, 1};
  int exp2 [5]  = '{2, 1, 0, 10, 9};
  int exp4 [6]  = '{0, 1, 2, 3, 4, 0};

  initial begin
    clr = 1'b1; en = 1'b0; up = 1'b1; ld = 1'b0; d = '0; m_wr = 1'b0; m_in = '0;
    repeat (2) cyc();
    clr = 1'b0;
    chk("rst_q", 0, int'(q_o[0]), 0);
    chk("rst_m", 0, int'(mcur_o[0]), 11);
    chk("rst_err", 0, int'(err_o[0]), 0);
    chk("rst_wrap", 0, int'(wrap_o[0]), 0);

    // count up through the wrap
    en = 1'b1;
    for (int k = 0; k < 13; k++) begin
      cyc();
      chk("up_seq", 0, int'(q_o[0]), exp1[k]);
      if (k == 10) chk("tc_top", 0, int'(tc_o[0]), 1);
      if (k == 11) chk("wrap_pulse", 0, int'(wrap_o[0]), 1);
    end

    // reverse: registered direction applies one edge later
    up = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("dn_seq", 0, int'(q_o[0]), exp2[k]);
      if (k == 2) chk("tc_bot", 0, int'(tc_o[0]), 1);
    end

    // range-checked load
    en = 1'b0; ld = 1'b1; d = 4'd12;
    cyc();
    chk("ld_bad_q", 0, int'(q_o[0]), 0);
    chk("ld_bad_err", 0, int'(err_o[0]), 1);
    d = 4'd7;
    cyc();
    chk("ld_ok_q", 0, int'(q_o[0]), 7);
    chk("ld_err_sticky", 0, int'(err_o[0]), 1);

    // shrinking modulus clips q
    d = 4'd9;
    cyc();
    chk("ld9", 0, int'(q_o[0]), 9);
    ld = 1'b0; m_wr = 1'b1; m_in = 4'd5;
    cyc();
    chk("clip_q", 0, int'(q_o[0]), 0);
    chk("clip_m", 0, int'(mcur_o[0]), 5);
    m_wr = 1'b0; en = 1'b1; up = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk("m5_seq", 0, int'(q_o[0]), exp4[k]);
    end

    // full range, then modulus 1
    m_wr = 1'b1; m_in = 4'd0;
    cyc();
    m_wr = 1'b0;
    chk("full_m", 0, int'(mcur_o[0]), 0);
    chk("full_q", 0, int'(q_o[0]), 1);
    repeat (14) cyc();
    chk("full_15", 0, int'(q_o[0]), 15);
    cyc();
    chk("full_wrap0", 0, int'(q_o[0]), 0);
    m_wr = 1'b1; m_in = 4'd1;
    cyc();
    m_wr = 1'b0;
    chk("m1_q", 0, int'(q_o[0]), 0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("m1_q_hold", 0, int'(q_o[0]), 0);
      chk("m1_tc_up", 0, int'(tc_o[0]), 1);
    end
    up = 1'b0;
    repeat (2) cyc();
    chk("m1_tc_dn", 0, int'(tc_o[0]), 1);
    chk("m1_q_dn", 0, int'(q_o[0]), 0);

    // async clear mid-count
    m_wr = 1'b1; m_in = 4'd11; up = 1'b1;
    cyc();
    m_wr = 1'b0;
    repeat (5) cyc();
    #2 clr = 1'b1;
    #1;
    chk("aclr_q", 0, int'(q_o[0]), 0);
    chk("aclr_q", 1, int'(q_o[1]), 0);
    chk("aclr_m", 0, int'(mcur_o[0]), 11);
    clr = 1'b0;
    cyc();
    chk("post_clr1", 0, int'(q_o[0]), 0);
    chk("post_clr1", 1, int'(q_o[1]), 1);
    cyc();
    chk("post_clr2", 0, int'(q_o[0]), 1);
    chk("post_clr2", 1, int'(q_o[1]), 2);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      cyc();
      en   = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) up = ~up;
      ld   = ($urandom_range(0, 15) == 0);
      d    = 4'($urandom_range(0, 15));
      m_wr = ($urandom_range(0, 15) == 0);
      m_in = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 199) == 0) begin
        #2 clr = 1'b1;
        #1 clr = 1'b0;
      end
    end
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
